tc_psum_drain: RTL and testbench

TC_PSUM_DRAIN -- requirements
Module: tc_psum_drain

---
 rtl/tc_pkg.sv | 28 ++
 rtl/tc_sync_fifo.sv | 82 ++++++++
 rtl/tc_psum_drain.sv | 96 +++++++++
 tb/tb_tc_psum_drain.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared constants, clog2 helper and occupancy-state encoding for the tensor-core drain path.
// No logic; no latency; no flow control.
// Consumed by tc_sync_fifo and tc_psum_drain via import.
package tc_pkg;

    localparam int TC_N       = 16;
    localparam int TC_DW_DATA = 8;
    localparam int TC_T_OUT   = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tc_sync_fifo.sv
// Synchronous row buffer: storage, wrapping pointers, occupancy and EMPTY/PARTIAL/FULL state.
// Latency: a push at edge t is visible on rdata/rd_vld from edge t; no fall-through when empty.
// Backpressure: caller must only push when !full or when popping in the same cycle.
module tc_sync_fifo
    import tc_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         rd_vld,
    output logic         full
);

    localparam int PW = clog2(DEPTH);
    localparam int OW = clog2(DEPTH + 1);
    localparam logic [OW-1:0] OCC_ALMOST = OW'(DEPTH - 1);
    localparam logic [OW-1:0] OCC_ONE    = OW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    occ_state_e    state_q, state_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        state_d  = state_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            state_d  = OCC_EMPTY;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      occ_d = occ_q + OW'(1);
            else if (pop && !push) occ_d = occ_q - OW'(1);
            case (state_q)
                OCC_EMPTY:   if (push) state_d = OCC_PARTIAL;
                OCC_PARTIAL: begin
                    if (push && !pop && occ_q == OCC_ALMOST)   state_d = OCC_FULL;
                    else if (pop && !push && occ_q == OCC_ONE) state_d = OCC_EMPTY;
                end
                OCC_FULL:    if (pop && !push) state_d = OCC_PARTIAL;
                default:     state_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            state_q  <= OCC_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            state_q  <= state_d;
        end
    end

    // Row storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata  = mem_q[rd_ptr_q];
    assign rd_vld = (state_q != OCC_EMPTY);
    assign full   = (state_q == OCC_FULL);

endmodule

// File: rtl/tc_psum_drain.sv
// Partial-sum drain: tags incoming rows with their tile row index and buffers them (optional ReLU via TC_DRAIN_RELU_EN).
// Latency: a row accepted at edge t appears on out_valid/out_data from edge t.
// Backpressure: input cannot stall; rows arriving while full with no pop are dropped and overflow sticks.
module tc_psum_drain
    import tc_pkg::*;
#(
    parameter int N       = TC_N,
    parameter int DW_DATA = TC_DW_DATA,
    parameter int T_OUT   = TC_T_OUT,
    parameter int DEPTH   = 4,
    localparam int DW_ROW = N * DW_DATA,
    localparam int DW_TAG = clog2(T_OUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DW_ROW-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW_ROW-1:0] out_data,
    output logic [DW_TAG-1:0] out_row,
    output logic              out_last,
    output logic              full,
    output logic              overflow
);

    localparam logic [DW_TAG-1:0] TAG_LAST = DW_TAG'(T_OUT - 1);

    logic [DW_TAG-1:0]        tag_q, tag_d;
    logic                     overflow_q, overflow_d;
    logic                     push, pop;
    logic                     fifo_vld, fifo_full;
    logic [DW_ROW-1:0]        row_in;
    logic [DW_ROW+DW_TAG-1:0] fifo_rdata;

    assign pop  = fifo_vld && out_ready && !clr;
    assign push = in_valid && !clr && (!fifo_full || pop);

`ifdef TC_DRAIN_RELU_EN
    always_comb begin
        row_in = in_data;
        for (int k = 0; k < N; k++) begin
            if (in_data[k*DW_DATA + DW_DATA - 1]) row_in[k*DW_DATA +: DW_DATA] = '0;
        end
    end
`else
    assign row_in = in_data;
`endif

    // The tag advances on every arriving row, dropped or not, so tile alignment survives drops.
    always_comb begin
        tag_d      = tag_q;
        overflow_d = overflow_q;
        if (clr) begin
            tag_d      = '0;
            overflow_d = 1'b0;
        end else if (in_valid) begin
            tag_d = (tag_q == TAG_LAST) ? '0 : tag_q + DW_TAG'(1);
            if (!push) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            tag_q      <= tag_d;
            overflow_q <= overflow_d;
        end
    end

    tc_sync_fifo #(
        .W     (DW_ROW + DW_TAG),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .push   (push),
        .pop    (pop),
        .wdata  ({row_in, tag_q}),
        .rdata  (fifo_rdata),
        .rd_vld (fifo_vld),
        .full   (fifo_full)
    );

    assign out_valid = fifo_vld;
    assign out_data  = fifo_vld ? fifo_rdata[DW_TAG +: DW_ROW] : '0;
    assign out_row   = fifo_vld ? fifo_rdata[DW_TAG-1:0] : '0;
    assign out_last  = fifo_vld && (out_row == TAG_LAST);
    assign full      = fifo_full;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_tc_psum_drain.sv
// Bench for tc_psum_drain: directed vector table, hand sequences for clr/reset/ReLU, then random traffic vs a queue model.
module tb_tc_psum_drain;

    localparam int N       = 16;
    localparam int DW_DATA = 8;
    localparam int T_OUT   = 16;
    localparam int DEPTH   = 4;
    localparam int DW_ROW  = N * DW_DATA;
    localparam int DW_TAG  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              in_valid;
    logic [DW_ROW-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW_ROW-1:0] out_data;
    logic [DW_TAG-1:0] out_row;
    logic              out_last;
    logic              full;
    logic              overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tc_psum_drain #(
        .N       (N),
        .DW_DATA (DW_DATA),
        .T_OUT   (T_OUT),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .full      (full),
        .overflow  (overflow)
    );

    // Reference model: a plain queue of stored rows plus the tile-row counter.
    typedef struct {
        logic [DW_ROW-1:0] d;
        int                tag;
    } ent_t;
    ent_t mq[$];
    int   m_tag = 0;
    bit   m_ovf = 0;

    typedef struct {
        logic       iv;
        logic [7:0] b;
        logic       rdy;
        logic       c;
        logic       e_vld;
        int         e_row;
        logic [7:0] e_b;
        logic       e_full;
        logic       e_ovf;
    } vec_t;
    vec_t tbl[22];

    function automatic logic [DW_ROW-1:0] fill(input logic [7:0] b);
        return {N{b}};
    endfunction

    function automatic logic [DW_ROW-1:0] relu(input logic [DW_ROW-1:0] d);
        logic [DW_ROW-1:0] r;
        r = d;
`ifdef TC_DRAIN_RELU_EN
        for (int k = 0; k < N; k++) if (d[k*DW_DATA + DW_DATA - 1]) r[k*DW_DATA +: DW_DATA] = '0;
`endif
        return r;
    endfunction

    function automatic logic [DW_ROW-1:0] rand_row();
        logic [DW_ROW-1:0] r;
        for (int k = 0; k < DW_ROW / 32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW_ROW-1:0] act, input logic [DW_ROW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic e_vld, input logic [DW_ROW-1:0] e_dat,
                           input int e_row, input logic e_last, input logic e_full, input logic e_ovf);
        chk({nm, ".out_valid"}, DW_ROW'(out_valid), DW_ROW'(e_vld));
        chk({nm, ".out_data"},  out_data,           e_dat);
        chk({nm, ".out_row"},   DW_ROW'(out_row),   DW_ROW'(e_row));
        chk({nm, ".out_last"},  DW_ROW'(out_last),  DW_ROW'(e_last));
        chk({nm, ".full"},      DW_ROW'(full),      DW_ROW'(e_full));
        chk({nm, ".overflow"},  DW_ROW'(overflow),  DW_ROW'(e_ovf));
    endtask

    task automatic model_reset();
        mq.delete();
        m_tag = 0;
        m_ovf = 0;
    endtask

    task automatic model_step(input logic iv, input logic [DW_ROW-1:0] d, input logic rdy, input logic c);
        bit   pop, push;
        ent_t e;
        if (c) begin
            model_reset();
        end else begin
            pop  = (mq.size() > 0) && rdy;
            push = iv && ((mq.size() < DEPTH) || pop);
            if (pop) e = mq.pop_front();
            if (push) begin
                e.d   = relu(d);
                e.tag = m_tag;
                mq.push_back(e);
            end
            if (iv && !push) m_ovf = 1;
            if (iv) m_tag = (m_tag + 1) % T_OUT;
        end
    endtask

    task automatic chk_model(input string nm);
        if (mq.size() > 0)
            chk_all(nm, 1'b1, mq[0].d, mq[0].tag, mq[0].tag == T_OUT - 1, mq.size() == DEPTH, m_ovf);
        else
            chk_all(nm, 1'b0, '0, 0, 1'b0, 1'b0, m_ovf);
    endtask

    task automatic cycle(input logic iv, input logic [DW_ROW-1:0] d, input logic rdy, input logic c);
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        clr       = c;
        model_step(iv, d, rdy, c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]        pat_in   [4];
        logic [7:0]        pat_relu [4];
        logic [DW_ROW-1:0] pin, pexp;

        pat_in   = '{8'h80, 8'hFF, 8'h7F, 8'h00};
        pat_relu = '{8'h00, 8'h00, 8'h7F, 8'h00};

        //          iv    b      rdy   clr  | vld  row  b      full  ovf
        tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1, 8'h01, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2, 8'h02, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3, 8'h03, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 5, 8'h05, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 0, 8'h21, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 0, 8'h21, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 8'h23, 1'b0, 1'b0, 1'b1, 0, 8'h21, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 8'h24, 1'b0, 1'b0, 1'b1, 0, 8'h21, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 8'h25, 1'b1, 1'b0, 1'b1, 1, 8'h22, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 8'h26, 1'b1, 1'b0, 1'b1, 2, 8'h23, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2, 8'h23, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3, 8'h24, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4, 8'h25, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5, 8'h26, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0};

        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        #3;
        chk_all("reset", 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Backpressure, drop, tag-after-drop, clr, simultaneous push/pop at full, hold
        for (int i = 0; i < 22; i++) begin
            cycle(tbl[i].iv, fill(tbl[i].b), tbl[i].rdy, tbl[i].c);
            chk_all($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_vld ? fill(tbl[i].e_b) : '0,
                    tbl[i].e_row, tbl[i].e_vld && tbl[i].e_row == T_OUT - 1, tbl[i].e_full, tbl[i].e_ovf);
        end

        // Basic streaming tile with one-cycle latency
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int r = 0; r < 16; r++) begin
            cycle(1'b1, fill(8'(r)), 1'b1, 1'b0);
            chk_all($sformatf("basic%0d", r), 1'b1, fill(8'(r)), r, r == 15, 1'b0, 1'b0);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("basic_drained.out_valid", DW_ROW'(out_valid), '0);

        // ReLU pattern
        for (int k = 0; k < N; k++) begin
            pin[k*8 +: 8] = pat_in[k % 4];
`ifdef TC_DRAIN_RELU_EN
            pexp[k*8 +: 8] = pat_relu[k % 4];
`else
            pexp[k*8 +: 8] = pat_in[k % 4];
`endif
        end
        cycle(1'b1, pin, 1'b0, 1'b0);
        chk("relu.out_data", out_data, pexp);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // clr with 3 buffered rows and overflow set, clr coinciding with in_valid
        for (int i = 0; i < 5; i++) cycle(1'b1, fill(8'h30 + 8'(i)), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk_all("pre_clr", 1'b1, fill(8'h31), 2, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, fill(8'h33), 1'b0, 1'b1);
        chk_all("clr", 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, fill(8'h44), 1'b0, 1'b0);
        chk_all("post_clr", 1'b1, fill(8'h44), 0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-pop
        cycle(1'b1, fill(8'h45), 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst", 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b1, fill(8'h46), 1'b0, 1'b0);
        chk_all("post_rst", 1'b1, fill(8'h46), 0, 1'b0, 1'b0, 1'b0);

        // Random traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 70, rand_row(), $urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 2);
            chk_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
